alu_cmd_sequencer: RTL and testbench

//  Upstream command stage for the 4-bit ALU. Accepts {opcode, a, b} commands over a

---
 rtl/alu_cmd_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command front-end for the 4-bit ALU: buffers {op, a, b} in a small FIFO, issues one
// command at a time and registers {result, carry, zero} behind a valid/ready handshake.
module alu_cmd_sequencer #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_zero,
  output logic [1:0]       res_op,
  output logic             busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned EW = 2 + 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop, full, empty;
  logic [1:0]       head_op;
  logic [WIDTH-1:0] head_a, head_b;

  logic [1:0]       alu_op_q, alu_op_d, res_op_q, res_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic             res_valid_q, res_valid_d, res_carry_q, res_carry_d, res_zero_q, res_zero_d;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = cmd_valid && !full;
  assign {head_op, head_a, head_b} = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_zero_d  = res_zero_q;
    res_op_d    = res_op_q;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop      = 1'b1;
          alu_op_d = head_op;
          alu_a_d  = head_a;
          alu_b_d  = head_b;
          state_d  = StExec;
        end
      end
      StExec: begin
        res_data_d  = alu_out;
        res_op_d    = alu_op_q;
        res_zero_d  = (alu_out == '0);
        // Only the arithmetic ops have a meaningful carry
        res_carry_d = alu_op_q[1] & alu_carry;
        res_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (!empty) begin
            pop      = 1'b1;
            alu_op_d = head_op;
            alu_a_d  = head_a;
            alu_b_d  = head_b;
            state_d  = StExec;
          end else begin
            state_d  = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_zero_q  <= 1'b0;
      res_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_zero_q  <= res_zero_d;
      res_op_q    <= res_op_d;
    end
  end

  assign cmd_ready = !full;
  assign busy      = (state_q != StIdle) || !empty;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_zero  = res_zero_q;
  assign res_op    = res_op_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a behavioural 4-bit ALU attached.
module tb_alu_cmd_sequencer;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid, cmd_ready, res_valid, res_ready, res_carry, res_zero, busy;
  logic [1:0]   cmd_op, alu_op, res_op;
  logic [W-1:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, res_data;
  logic         alu_carry;
  logic [W:0]   alu_sum;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  logic       stall_seen = 1'b0;
  logic [7:0] stall_val;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.WIDTH(W), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry), .res_zero(res_zero),
    .res_op(res_op), .busy(busy)
  );

  // ALU carry comes from the adder for every op, so AND/OR masking is exercised
  always_comb begin
    alu_sum = alu_op[0] ? ({1'b0, alu_a} + {1'b0, ~alu_b}) : ({1'b0, alu_a} + {1'b0, alu_b});
    case (alu_op)
      2'b00:   alu_out = alu_a & alu_b;
      2'b01:   alu_out = alu_a | alu_b;
      default: alu_out = alu_sum[W-1:0];
    endcase
    alu_carry = alu_sum[W];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_res(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] d;
    s = (op == 2'b11) ? ({1'b0, a} + {1'b0, ~b}) : ({1'b0, a} + {1'b0, b});
    case (op)
      2'b00:   d = a & b;
      2'b01:   d = a | b;
      default: d = s[W-1:0];
    endcase
    return {op, d, op[1] & s[W], d == '0};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        check_val("hold_valid", res_valid, 1);
        check_val("hold_data", {res_op, res_data, res_carry, res_zero}, stall_val);
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(exp_res(cmd_op, cmd_a, cmd_b));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check_val("unexpected_res", res_valid, 0);
        else check_val("res", {res_op, res_data, res_carry, res_zero}, exp_q.pop_front());
      end
      stall_seen = res_valid && !res_ready;
      stall_val  = {res_op, res_data, res_carry, res_zero};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    for (int i = 0; i < 300 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    check_val("send_accept", acc, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || busy); i++) tick();
    check_val("drain_empty", exp_q.size(), 0);
    check_val("drain_busy", busy, 0);
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_ready"}, cmd_ready, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_alu"}, {alu_op, alu_a, alu_b}, 0);
    check_val({tag, "_res"}, {res_valid, res_op, res_data, res_carry, res_zero}, 0);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b0;
    repeat (2) tick();
    check_cleared("reset");
    rst_n = 1'b1;
    tick();

    // Latency: accepted at edge k, result visible after edge k+2
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_a = 4'h7; cmd_b = 4'h5;
    tick();
    cmd_valid = 1'b0;
    check_val("lat_k", res_valid, 0);
    check_val("busy_k", busy, 1);
    tick();
    check_val("lat_k1", res_valid, 0);
    tick();
    check_val("lat_k2", res_valid, 1);
    check_val("lat_data", {res_data, res_carry, res_zero}, {4'hC, 2'b00});
    drain();

    send(2'b10, 4'hF, 4'h1);
    send(2'b11, 4'h5, 4'h3);
    send(2'b00, 4'hC, 4'hA);
    send(2'b01, 4'hC, 4'hA);
    drain();
    check_val("alu_hold", {alu_op, alu_a, alu_b}, {2'b01, 4'hC, 4'hA});

    // Backpressure: FIFO fills behind a stalled result
    res_ready = 1'b0;
    send(2'b10, 4'h1, 4'h2);
    send(2'b11, 4'h9, 4'h4);
    send(2'b01, 4'h3, 4'h4);
    tick();
    check_val("full_ready", cmd_ready, 0);
    check_val("full_valid", res_valid, 1);
    fork
      send(2'b00, 4'hF, 4'h6);
      begin
        repeat (4) tick();
        check_val("full_stall", cmd_ready, 0);
        res_ready = 1'b1;
      end
    join
    drain();

    // Streaming with gaps (push/pop on the same edge, pointer wrap)
    res_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();

    fork
      for (int i = 0; i < 16; i++) send(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
      for (int i = 0; i < 120; i++) begin
        res_ready = 1'($urandom_range(0, 1));
        tick();
      end
    join
    res_ready = 1'b1;
    drain();

    // Reset while a command is executing and another is queued
    res_ready = 1'b0;
    send(2'b10, 4'h2, 4'h2);
    send(2'b10, 4'h3, 4'h3);
    send(2'b10, 4'h4, 4'h4);
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_cleared("midrst");
    repeat (2) tick();
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("post_rst_valid", res_valid, 0);
    end
    send(2'b11, 4'h0, 4'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
